// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan path: scheduler state encoding,
// default result width and the channel-index width helper.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int RES_W_DEF = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel strictly after last_grant,
// wrapping around. Purely combinational.
module rr_arbiter
  import adc_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = ch_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last_grant,
  output logic           any_req,
  output logic [CW-1:0]  grant_idx
);

  logic [CW-1:0] idx;

  // Scan last_grant+1 .. last_grant+NCH; the last step revisits last_grant
  // itself so a lone requester can be granted back-to-back.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = last_grant;
    idx       = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(last_grant) + i) % NCH);
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Shares one SAR ADC controller and its input mux among NCH requesters:
// round-robin grant, mux settle, go/valid handshake with timeout, and a
// one-cycle result/ack (or err) pulse back to the winner.
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int RES_W         = RES_W_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 32,
  localparam int CW           = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   ack,
  output logic [RES_W-1:0] data,
  output logic [CW-1:0]    data_ch,
  output logic             data_valid,
  output logic             err,
  output logic             busy,
  output logic [CW-1:0]    mux_sel,
  output logic             adc_go,
  input  logic             adc_valid,
  input  logic [RES_W-1:0] adc_result
);

  localparam int SW = 4;
  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  logic [CW-1:0] last_grant;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;
  logic          any_req;
  logic [CW-1:0] grant_idx;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .grant_idx  (grant_idx)
  );

  // Scheduler FSM with registered outputs. The result/err pulse is loaded on
  // the CONVERT->RELEASE transition so it is visible exactly during the
  // RELEASE cycle; the success/timeout outcome is decided right there, so no
  // separate pending flag needs to be kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= CW'(NCH - 1);
      settle_cnt <= '0;
      to_cnt     <= '0;
      mux_sel    <= '0;
      adc_go     <= 1'b0;
      busy       <= 1'b0;
      ack        <= '0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack        <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mux_sel    <= grant_idx;
            last_grant <= grant_idx;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            to_cnt <= '0;
            adc_go <= 1'b1;
            state  <= CONVERT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CONVERT: begin
          // A result on the final timeout cycle still counts as success.
          if (adc_valid) begin
            data       <= adc_result;
            data_ch    <= last_grant;
            data_valid <= 1'b1;
            ack        <= NCH'(1) << last_grant;
            adc_go     <= 1'b0;
            state      <= RELEASE;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            err    <= 1'b1;
            adc_go <= 1'b0;
            state  <= RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
